// File: rtl/pwm_generator_if.sv
// pwm_generator_if: top/compare stream from the PWM sequencer into the PWM
// generator, plus the generator's output strobes.
//   i_top / i_top_valid         : new period top (period = top+1), valid-only strobe
//   i_compare / i_compare_valid : new compare (duty) value, valid-only strobe
//   o_pwm                       : registered PWM output
//   o_period_start              : one-cycle strobe for the count-0 output cycle
//   o_update                    : one-cycle strobe for the first period on new values
// master = sequencer side, slave = generator side.
interface pwm_generator_if #(
  parameter int TOP_W = 8,
  parameter int CMP_W = TOP_W + 1
);
  logic [TOP_W-1:0] i_top;
  logic             i_top_valid;
  logic [CMP_W-1:0] i_compare;
  logic             i_compare_valid;
  logic             o_pwm;
  logic             o_period_start;
  logic             o_update;

  modport master (
    output i_top, i_top_valid, i_compare, i_compare_valid,
    input  o_pwm, o_period_start, o_update
  );

  modport slave (
    input  i_top, i_top_valid, i_compare, i_compare_valid,
    output o_pwm, o_period_start, o_update
  );
endinterface

// File: rtl/pwm_generator.sv
// pwm_generator: single-channel PWM with double-buffered period/compare.
// New top/compare values are captured into shadow registers on their strobes
// and only copied into the active registers at the period boundary, so the
// output never glitches mid-period.
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : pwm_generator_if slave (top/compare strobes in, pwm/strobes out)
module pwm_generator #(
  parameter int               TOP_W     = 8,
  parameter int               CMP_W     = TOP_W + 1,
  parameter logic [TOP_W-1:0] RESET_TOP = TOP_W'(8'hFF),
  parameter logic [CMP_W-1:0] RESET_CMP = CMP_W'(0)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pwm_generator_if.slave bus
);

  logic [TOP_W-1:0] c;
  logic [TOP_W-1:0] top_act, top_pend;
  logic [CMP_W-1:0] cmp_act, cmp_pend;
  logic             top_pf, cmp_pf;
  logic             applied;     // last edge was a boundary that loaded new values
  logic             pwm_q, ps_q, upd_q;
  logic             boundary;

  assign boundary = (c == top_act);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c        <= '0;
      top_act  <= RESET_TOP;
      cmp_act  <= RESET_CMP;
      top_pend <= '0;
      cmp_pend <= '0;
      top_pf   <= 1'b0;
      cmp_pf   <= 1'b0;
      applied  <= 1'b0;
      pwm_q    <= 1'b0;
      ps_q     <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      c <= boundary ? '0 : c + TOP_W'(1);

      if (boundary) begin
        // A strobe landing on the boundary cycle bypasses the shadow and
        // overrides any older pending value.
        if (bus.i_top_valid)     top_act <= bus.i_top;
        else if (top_pf)         top_act <= top_pend;
        if (bus.i_compare_valid) cmp_act <= bus.i_compare;
        else if (cmp_pf)         cmp_act <= cmp_pend;
        top_pf <= 1'b0;
        cmp_pf <= 1'b0;
      end else begin
        // Last strobe before the boundary wins.
        if (bus.i_top_valid) begin
          top_pend <= bus.i_top;
          top_pf   <= 1'b1;
        end
        if (bus.i_compare_valid) begin
          cmp_pend <= bus.i_compare;
          cmp_pf   <= 1'b1;
        end
      end

      applied <= boundary &
                 (bus.i_top_valid | top_pf | bus.i_compare_valid | cmp_pf);

      // Compare at CMP_W so cmp_act > top_act gives 100% duty.
      pwm_q <= (CMP_W'(c) < cmp_act);
      ps_q  <= (c == '0);
      // Delayed one edge so it lines up with o_period_start of the new period.
      upd_q <= applied;
    end
  end

  assign bus.o_pwm          = pwm_q;
  assign bus.o_period_start = ps_q;
  assign bus.o_update       = upd_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed test of pwm_generator (TOP_W=8, CMP_W=9).
// Each scenario starts from a fresh reset so the counter phase is known:
// after reset release, edge n leaves c = n mod (top+1) and the outputs seen
// after edge n reflect the count of the cycle before it.
module tb_pwm_generator;
  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 i_clk = ~i_clk;

  pwm_generator_if #(.TOP_W(8), .CMP_W(9)) bus ();

  pwm_generator #(
    .TOP_W(8), .CMP_W(9), .RESET_TOP(8'hFF), .RESET_CMP(9'h000)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic p, input logic s, input logic u);
    chk({tag, "_pwm"}, bus.o_pwm, p);
    chk({tag, "_ps"},  bus.o_period_start, s);
    chk({tag, "_upd"}, bus.o_update, u);
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input int n, input logic p, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, bus.o_pwm, p);
    end
  endtask

  task automatic clr();
    bus.i_top_valid     = 1'b0;
    bus.i_compare_valid = 1'b0;
  endtask

  task automatic set_top(input logic [7:0] v);
    bus.i_top       = v;
    bus.i_top_valid = 1'b1;
  endtask

  task automatic set_cmp(input logic [8:0] v);
    bus.i_compare       = v;
    bus.i_compare_valid = 1'b1;
  endtask

  task automatic do_reset();
    clr();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    bus.i_top = '0;
    bus.i_compare = '0;
    clr();

    // Reset state
    #1 outs("rst", 1'b0, 1'b0, 1'b0);

    // Default: pwm low, period_start at 1, 257, 513, no update
    do_reset();
    for (int n = 1; n <= 600; n++) begin
      step();
      outs("dflt", 1'b0, (n == 1 || n == 257 || n == 513), 1'b0);
    end

    // top=3 cmp=2 loaded at count 100: old period finishes, then 1,1,0,0
    do_reset();
    repeat (100) step();
    set_top(8'd3);
    set_cmp(9'd2);
    step();
    clr();
    run(155, 1'b0, "t2_old");
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) begin
        step();
        outs("t2_new", (i < 2), (i == 0), (p == 0 && i == 0));
      end

    // 100%, then 0%, then saturated compare
    do_reset();
    set_cmp(9'h100);
    run(1, 1'b0, "t3_a");
    clr();
    run(255, 1'b0, "t3_b");
    run(1, 1'b1, "t3_c");
    set_cmp(9'h000);
    run(1, 1'b1, "t3_d");
    clr();
    run(254, 1'b1, "t3_e");
    run(1, 1'b0, "t3_f");
    set_cmp(9'h1FF);
    run(1, 1'b0, "t3_g");
    clr();
    run(254, 1'b0, "t3_h");
    run(32, 1'b1, "t3_i");

    // top=0: every cycle a boundary
    do_reset();
    set_top(8'd0);
    set_cmp(9'd1);
    step();
    clr();
    repeat (255) step();
    step();
    outs("t4_first", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      outs("t4_run", 1'b1, 1'b1, 1'b0);
    end
    set_cmp(9'd0);
    step();
    outs("t4_s1", 1'b1, 1'b1, 1'b0);
    clr();
    step();
    outs("t4_s2", 1'b0, 1'b1, 1'b1);
    step();
    outs("t4_s3", 1'b0, 1'b1, 1'b0);

    // top=7 cmp=4; cmp=6 at count 3, then cmp=2 on the boundary cycle
    do_reset();
    set_top(8'd7);
    set_cmp(9'd4);
    step();
    clr();
    repeat (263) step();
    step(); outs("t5_c0", 1'b1, 1'b1, 1'b0);
    step(); outs("t5_c1", 1'b1, 1'b0, 1'b0);
    step(); outs("t5_c2", 1'b1, 1'b0, 1'b0);
    set_cmp(9'd6);
    step(); outs("t5_c3", 1'b1, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 3; i++) begin
      step(); outs("t5_c456", 1'b0, 1'b0, 1'b0);
    end
    set_cmp(9'd2);
    step(); outs("t5_c7", 1'b0, 1'b0, 1'b0);
    clr();
    step(); outs("t5_n0", 1'b1, 1'b1, 1'b1);
    step(); outs("t5_n1", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(); outs("t5_nlow", 1'b0, 1'b0, 1'b0);
    end
    step(); outs("t5_m0", 1'b1, 1'b1, 1'b0);
    step(); outs("t5_m1", 1'b1, 1'b0, 1'b0);
    step(); outs("t5_m2", 1'b0, 1'b0, 1'b0);

    // Reset mid-period with a pending top: outputs drop without a clock
    do_reset();
    set_cmp(9'h1FF);
    step();
    clr();
    repeat (255) step();
    set_top(8'd3);
    step();
    outs("t6_pre", 1'b1, 1'b1, 1'b1);
    clr();
    #2 i_rst_n = 1'b0;
    #1 outs("t6_async", 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      step();
      outs("t6_dflt", 1'b0, (n == 1 || n == 257), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_generator.md
# pwm_generator

Consumer end of the PWM sequencer's top/compare stream. Accepts period (`top`) and duty (`compare`) values on valid-only strobes and holds them in double-buffered shadow registers. Applies them glitch-free at the next period boundary and drives a single-bit PWM output plus period and update strobes. Sits between the sequencer and the LED/output pin drivers.

## Interface
- `TOP_W`, default 8, width of the period-top value.
- `CMP_W`, default `TOP_W+1`, width of the compare value. The extra bit allows 100% duty.
- `RESET_TOP`, default `8'hFF`, active top after reset.
- `RESET_CMP`, default `9'h000`, active compare after reset (output low).

Ports:
- `i_clk`  in  1  system clock; all logic is on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_top`  in  TOP_W  new period top; the period is `top+1` cycles.
- `i_top_valid`  in  1  single-cycle strobe qualifying `i_top`. There is no ready; the value is always accepted.
- `i_compare`  in  CMP_W  new compare value.
- `i_compare_valid`  in  1  single-cycle strobe qualifying `i_compare`. There is no ready; the value is always accepted.
- `o_pwm`  out  1  registered PWM output.
- `o_period_start`  out  1  registered one-cycle strobe marking the output cycle for count 0.
- `o_update`  out  1  registered one-cycle strobe marking the first output cycle of a period that uses newly applied values.

## Operation
- State:
  - counter `c` (TOP_W)
  - `top_act`, `cmp_act`
  - `top_pend`, `cmp_pend`
  - flags `top_pf`, `cmp_pf`
- Reset (async assert, takes effect immediately without a clock):
  - `c=0`, `top_act=RESET_TOP`, `cmp_act=RESET_CMP`
  - pending flags 0
  - `o_pwm=0`, `o_period_start=0`, `o_update=0`
- Counter: `c` runs `0..top_act` inclusive, then wraps to 0.
- Boundary: the cycle with `c==top_act`.
- Capture:
  - `i_top_valid` loads `top_pend` and sets `top_pf`.
  - `i_compare_valid` does the same for `cmp_pend` / `cmp_pf`.
  - Multiple strobes before a boundary: the last one wins.
- Apply at the boundary edge (top and compare handled independently):
  - `top_act <= i_top_valid ? i_top : (top_pf ? top_pend : top_act)`.
  - Same rule for compare.
  - A strobe on the boundary cycle itself bypasses the shadow and takes effect in the very next period, overriding any older pending value.
  - Both pending flags clear.
- Mid-period strobes never disturb `top_act`/`cmp_act`, so the output never glitches.
- Output compare: `o_pwm <= ({1'b0,c} < cmp_act)`, compared at CMP_W width.
  - `cmp_act = 0`: always low.
  - `cmp_act >= top_act+1`: always high.
- Strobes:
  - `o_period_start <= (c==0)`.
  - `o_update <=` (the previous edge was a boundary that applied at least one new value).

## Timing
- `o_pwm` and `o_period_start` lag the counter by one cycle. `o_update` coincides with `o_period_start` for the first period using new values.
- After reset release, the first edge produces `o_period_start=1`. `o_pwm` is 0 throughout with the default `RESET_CMP`.
- Load-to-effect latency:
  - From a strobe at count `k`: `(top_act-k)+2` cycles until the first affected `o_pwm` cycle.
  - A strobe on the boundary cycle has 2 cycles latency.
- `top_act=0`: every cycle is a boundary, and `o_period_start` stays high continuously.
  - Updates apply on the edge after their strobe.
  - `o_update` pulses once per applied strobe.
- High time is `min(cmp_act, top_act+1)` cycles per `top_act+1`-cycle period.
- Reset asserted mid-period: outputs drop within the same cycle without a clock edge. Pending values are discarded.

## Test plan
- Default: after reset with no strobes, `o_pwm=0` for 600 cycles. `o_period_start` pulses at cycles 1, 257, 513. `o_update` never pulses.
- Load `top=3`, `cmp=2` at count 100 → the current 256-cycle period finishes unchanged. Then `o_pwm` repeats 1,1,0,0. `o_update` pulses once, aligned with the first `o_period_start` of the new pattern.
- `top=255`, `cmp=9'h100` → `o_pwm` is constantly 1. Then `cmp=0` → constantly 0 from the next period onward. Then `cmp=9'h1FF` → constantly 1.
- `top=0`, `cmp=1` → `o_pwm=1` and `o_period_start=1` every cycle. A compare strobe of 0 drives `o_pwm` to 0 two cycles after the strobe.
- `top=7`, `cmp=4`. Strobe `cmp=6` at count 3, then `cmp=2` on the boundary cycle (count 7) → the next period uses 2: 2 high, 6 low. `o_update` pulses once.
- Assert `i_rst_n=0` mid-period with a pending update → `o_pwm`, `o_period_start` and `o_update` go to 0 immediately. After release, the default behaviour resumes and the pending value is never applied.
